// File: rtl/mem_access.sv
// Memory-access stage: load/store over a multi-cycle data bus,
// with lane alignment, sign/zero extension and pipeline hold.
module mem_access #(
  parameter int         TIMEOUT  = 255,
  parameter logic [7:0] LOAD_OP  = 8'h01,
  parameter logic [7:0] STORE_OP = 8'h02
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [7:0]  ex_aluop,
  input  logic [2:0]  ex_alufun3,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_reg2,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] result;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        ld_q;
  logic        err_q;

  logic        is_ld, is_st, is_mem, aligned;
  logic [3:0]  sel_n;
  logic [31:0] wdat_n;
  logic [31:0] sh;
  logic [31:0] ext;
  logic        unused;

  assign unused = ^{stall[5], stall[3:0]};

  assign is_ld  = ex_aluop == LOAD_OP;
  assign is_st  = ex_aluop == STORE_OP;
  assign is_mem = is_ld | is_st;

  always_comb begin
    aligned = 1'b0;
    sel_n   = 4'b1111;
    wdat_n  = ex_reg2;
    case (ex_alufun3[1:0])
      2'b00: begin
        aligned = 1'b1;
        sel_n   = 4'b0001 << ex_mem_addr[1:0];
        wdat_n  = {4{ex_reg2[7:0]}};
      end
      2'b01: begin
        aligned = ~ex_mem_addr[0];
        sel_n   = ex_mem_addr[1] ? 4'b1100 : 4'b0011;
        wdat_n  = {2{ex_reg2[15:0]}};
      end
      2'b10: aligned = ex_mem_addr[1:0] == 2'b00;
      default: aligned = 1'b0;
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend per funct3[2]
  assign sh = bus_rdata >> {off_q, 3'b000};

  always_comb begin
    ext = bus_rdata;
    case (f3_q[1:0])
      2'b00: ext = f3_q[2] ? {24'h0, sh[7:0]}
                           : {{24{sh[7]}}, sh[7:0]};
      2'b01: ext = f3_q[2] ? {16'h0, sh[15:0]}
                           : {{16{sh[15]}}, sh[15:0]};
      default: ext = bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_sel   <= '0;
      bus_wdata <= '0;
      cnt       <= '0;
      result    <= '0;
      off_q     <= '0;
      f3_q      <= '0;
      ld_q      <= 1'b0;
      err_q     <= 1'b0;
      bus_err_o <= 1'b0;
    end else begin
      bus_err_o <= 1'b0;
      case (state)
        IDLE: if (is_mem && aligned) begin
          state     <= BUSY;
          bus_req   <= 1'b1;
          bus_we    <= is_st;
          bus_addr  <= {ex_mem_addr[31:2], 2'b00};
          bus_sel   <= sel_n;
          bus_wdata <= wdat_n;
          cnt       <= '0;
          off_q     <= ex_mem_addr[1:0];
          f3_q      <= ex_alufun3;
          ld_q      <= is_ld;
          err_q     <= 1'b0;
        end
        BUSY: if (bus_ack) begin
          state   <= DONE;
          bus_req <= 1'b0;
          bus_we  <= 1'b0;
          result  <= ext;
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          state     <= DONE;
          bus_req   <= 1'b0;
          bus_we    <= 1'b0;
          result    <= '0;
          err_q     <= 1'b1;
          bus_err_o <= 1'b1;
        end else begin
          cnt <= cnt + 8'd1;
        end
        DONE: if (!stall[4]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign misalign_o = !rst && state == IDLE && is_mem && !aligned;

  always_comb begin
    wd_o     = '0;
    wreg_o   = 1'b0;
    wdata_o  = '0;
    stallreq = 1'b0;
    if (!rst) begin
      wd_o = ex_wd;
      case (state)
        IDLE: begin
          wreg_o   = ex_wreg & ~is_mem;
          wdata_o  = ex_wdata;
          stallreq = is_mem & aligned;
        end
        BUSY: begin
          wdata_o  = ex_wdata;
          stallreq = 1'b1;
        end
        DONE: begin
          wreg_o  = ex_wreg & ld_q & ~err_q;
          wdata_o = result;
        end
        default: ;
      endcase
    end
  end

endmodule
